// File: rtl/reset_sequencer_pkg.sv
// Shared reset-domain definitions: FSM state encoding used by the reset
// sequencer and reusable by other reset_stretch-family blocks.
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOLD     = 3'd1,
    WAIT_RDY = 3'd2,
    RUN      = 3'd3,
    ERROR    = 3'd4
  } rst_state_e;

  // Width of a stage index; a single-stage build still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// sync_bit: two-flop synchronizer with asynchronous clear, used for each
// asynchronous stage_ready input of the reset sequencer.
module sync_bit (
  input  logic clk,
  input  logic rst_in,
  input  logic d,
  output logic q
);

  logic [1:0] ff = '0;

  // Shift the asynchronous input through two flops; clear on reset.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) ff <= '0;
    else        ff <= {ff[0], d};
  end

  assign q = ff[1];

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases STAGES reset domains strictly in index order,
// holding each for 2^HOLD_W clocks and then waiting for its ready.
// Optional macro RESET_SEQ_TIMEOUT_EN adds the ready-wait timeout counter,
// the ERROR state and a sticky timeout_err; without it timeout_err is 0.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned HOLD_W    = 4,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic              clk,
  input  logic              rst_in,
  input  logic              sw_rst_req,
  input  logic [STAGES-1:0] stage_ready,
  output logic [STAGES-1:0] rst_out,
  output logic              done,
  output logic              timeout_err
);

  localparam int unsigned      IDX_W = idx_width(STAGES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(STAGES - 1);

  if (STAGES < 1 || STAGES > 8 || HOLD_W < 1 || TIMEOUT_W < 1) begin : g_bad_cfg
    $error("reset_sequencer: parameter out of range");
  end

  logic [STAGES-1:0] ready_s;

  for (genvar g = 0; g < STAGES; g++) begin : g_sync
    sync_bit u_sync (
      .clk    (clk),
      .rst_in (rst_in),
      .d      (stage_ready[g]),
      .q      (ready_s[g])
    );
  end

  rst_state_e        state    = IDLE;
  rst_state_e        state_nxt;
  logic [IDX_W-1:0]  idx      = '0;
  logic [IDX_W-1:0]  idx_nxt;
  logic [HOLD_W-1:0] hold_cnt = '0;
  logic [HOLD_W-1:0] hold_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic [STAGES-1:0] rst_q    = '1;
  logic [STAGES-1:0] rst_nxt;
  logic              done_q   = 1'b0;
  logic              done_nxt;

  assign hold_inc = hold_cnt + HOLD_W'(1);
  assign rst_out  = rst_q;
  assign done     = done_q;

`ifdef RESET_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt = '0;
  logic [TIMEOUT_W-1:0] tmo_nxt;
  logic                 terr_q  = 1'b0;
  logic                 terr_nxt;

  assign timeout_err = terr_q;

  // Timeout counter runs only while staying in WAIT_RDY, cleared otherwise.
  always_comb begin
    tmo_nxt = '0;
    if (state == WAIT_RDY && state_nxt == WAIT_RDY) tmo_nxt = tmo_cnt + TIMEOUT_W'(1);
  end

  // Timeout state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      tmo_cnt <= '0;
      terr_q  <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      terr_q  <= terr_nxt;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // Next-state and registered-output logic; sw_rst_req overrides everything.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    hold_nxt  = hold_cnt;
    rst_nxt   = rst_q;
    done_nxt  = done_q;
`ifdef RESET_SEQ_TIMEOUT_EN
    terr_nxt  = terr_q;
`endif
    if (state != IDLE && sw_rst_req) begin
      state_nxt = HOLD;
      idx_nxt   = '0;
      hold_nxt  = '0;
      rst_nxt   = '1;
      done_nxt  = 1'b0;
`ifdef RESET_SEQ_TIMEOUT_EN
      terr_nxt  = 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          state_nxt = HOLD;
          idx_nxt   = '0;
          hold_nxt  = '0;
        end
        HOLD: begin
          // Release on the edge the counter would reach all-ones, so the
          // entry edge counts as the first of 2^HOLD_W hold edges.
          if (hold_inc == '1) begin
            rst_nxt[idx] = 1'b0;
            hold_nxt     = '0;
            state_nxt    = WAIT_RDY;
          end else begin
            hold_nxt = hold_inc;
          end
        end
        WAIT_RDY: begin
          if (ready_s[idx]) begin
            hold_nxt = '0;
            if (idx == LAST) begin
              state_nxt = RUN;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = HOLD;
              idx_nxt   = idx + IDX_W'(1);
            end
          end
`ifdef RESET_SEQ_TIMEOUT_EN
          else if (tmo_cnt == '1) begin
            state_nxt = ERROR;
            terr_nxt  = 1'b1;
            rst_nxt   = '1;
            done_nxt  = 1'b0;
          end
`endif
        end
        RUN: begin
          if (!(&ready_s)) begin
            state_nxt = HOLD;
            idx_nxt   = '0;
            hold_nxt  = '0;
            rst_nxt   = '1;
            done_nxt  = 1'b0;
          end
        end
`ifdef RESET_SEQ_TIMEOUT_EN
        ERROR: state_nxt = ERROR;
`endif
        default: begin
          state_nxt = IDLE;
          idx_nxt   = '0;
          hold_nxt  = '0;
          rst_nxt   = '1;
          done_nxt  = 1'b0;
        end
      endcase
    end
  end

  // FSM and output registers; rst_in forces all domains into reset at once.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      idx      <= '0;
      hold_cnt <= '0;
      rst_q    <= '1;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      hold_cnt <= hold_nxt;
      rst_q    <= rst_nxt;
      done_q   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (STAGES=2, HOLD_W=2, TIMEOUT_W=4).
// Expectations are queued as stimulus is applied and compared against the
// outputs sampled 1 time unit after the clock edge where they should appear.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst_in = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic [1:0] stage_ready = 2'b11;
  logic [1:0] rst_out;
  logic       done;
  logic       timeout_err;

`ifdef RESET_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [1:0] rst;
    logic       dn;
    logic       te;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  reset_sequencer #(
    .STAGES    (2),
    .HOLD_W    (2),
    .TIMEOUT_W (4)
  ) dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .sw_rst_req  (sw_rst_req),
    .stage_ready (stage_ready),
    .rst_out     (rst_out),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] r, input logic d, input logic t);
    exp_t e;
    e.tag = tag;
    e.rst = r;
    e.dn  = d;
    e.te  = t;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 entries expected=1 entry");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_assert++;
      assert (rst_out === e.rst) else begin
        n_fail++;
        $error("FAIL %s.rst_out observed=%b expected=%b", e.tag, rst_out, e.rst);
      end
      n_assert++;
      assert (done === e.dn) else begin
        n_fail++;
        $error("FAIL %s.done observed=%b expected=%b", e.tag, done, e.dn);
      end
      n_assert++;
      assert (timeout_err === e.te) else begin
        n_fail++;
        $error("FAIL %s.timeout_err observed=%b expected=%b", e.tag, timeout_err, e.te);
      end
    end
  endtask

  initial begin
    // Power-up values without any rst_in pulse.
    #1;
    expect_out("init", 2'b11, 1'b0, 1'b0); check_out();
    rst_in = 1'b1;
    tick(3);
    expect_out("reset", 2'b11, 1'b0, 1'b0); check_out();

    // Normal bring-up with both readies held high.
    rst_in = 1'b0;
    expect_out("up_e3", 2'b11, 1'b0, 1'b0); tick(3); check_out();
    expect_out("up_e4", 2'b10, 1'b0, 1'b0); tick(1); check_out();
    expect_out("up_e7", 2'b10, 1'b0, 1'b0); tick(3); check_out();
    expect_out("up_e8", 2'b00, 1'b0, 1'b0); tick(1); check_out();
    expect_out("up_e9", 2'b00, 1'b1, 1'b0); tick(1); check_out();
    expect_out("run",   2'b00, 1'b1, 1'b0); tick(4); check_out();

    // Ready[0] drops for 5 cycles while running.
    stage_ready = 2'b10;
    expect_out("drop_e3", 2'b11, 1'b0, 1'b0); tick(3); check_out();
    tick(2);
    stage_ready = 2'b11;
    expect_out("drop_e6",  2'b10, 1'b0, 1'b0); tick(1); check_out();
    expect_out("drop_e11", 2'b00, 1'b0, 1'b0); tick(5); check_out();
    expect_out("drop_e12", 2'b00, 1'b1, 1'b0); tick(1); check_out();

    // Software restart, then a second request on the hold-expiry edge.
    sw_rst_req = 1'b1;
    expect_out("sw_e1", 2'b11, 1'b0, 1'b0); tick(1); check_out();
    sw_rst_req = 1'b0;
    tick(2);
    sw_rst_req = 1'b1;
    expect_out("sw_expiry", 2'b11, 1'b0, 1'b0); tick(1); check_out();
    sw_rst_req = 1'b0;
    expect_out("sw_e6", 2'b11, 1'b0, 1'b0); tick(2); check_out();
    expect_out("sw_e7", 2'b10, 1'b0, 1'b0); tick(1); check_out();
    expect_out("sw_e9", 2'b10, 1'b0, 1'b0); tick(2); check_out();

    // rst_in during the stage-1 hold acts before the next clock edge.
    rst_in = 1'b1;
    #2;
    expect_out("async_rst", 2'b11, 1'b0, 1'b0); check_out();
    stage_ready = 2'b01;
    tick(2);

    // Stage 1 never becomes ready: ready-wait timeout.
    rst_in = 1'b0;
    expect_out("tmo_e4",  2'b10, 1'b0, 1'b0); tick(4); check_out();
    expect_out("tmo_e8",  2'b00, 1'b0, 1'b0); tick(4); check_out();
    expect_out("tmo_e23", 2'b00, 1'b0, 1'b0); tick(15); check_out();
    expect_out("tmo_e24", TMO_EN ? 2'b11 : 2'b00, 1'b0, TMO_EN); tick(1); check_out();
    expect_out("tmo_hold", TMO_EN ? 2'b11 : 2'b00, 1'b0, TMO_EN); tick(20); check_out();

    // Recovery: ready[1] rises, software restart completes the sequence.
    stage_ready = 2'b11;
    tick(3);
    sw_rst_req = 1'b1;
    expect_out("rec_e4", 2'b11, 1'b0, 1'b0); tick(1); check_out();
    sw_rst_req = 1'b0;
    expect_out("rec_e7",  2'b10, 1'b0, 1'b0); tick(3); check_out();
    expect_out("rec_e11", 2'b00, 1'b0, 1'b0); tick(4); check_out();
    expect_out("rec_e12", 2'b00, 1'b1, 1'b0); tick(1); check_out();

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d entries expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter STAGES, default 3: number of sequenced reset domains, range 1..8.
REQ-002 SHALL have parameter HOLD_W, default 4: per-stage hold of 2^HOLD_W clocks before release.
REQ-003 SHALL have parameter TIMEOUT_W, default 16: ready-wait timeout of 2^TIMEOUT_W clocks.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: synchronous single-cycle software restart request.
REQ-007 SHALL have port stage_ready, input, STAGES bits: per-domain ready, asynchronous (e.g. PLL lock, PHY ready).
REQ-008 SHALL have port rst_out, output, STAGES bits: per-domain reset, active-high, registered.
REQ-009 SHALL have port done, output, 1 bit: all stages released and ready.
REQ-010 SHALL have port timeout_err, output, 1 bit: sticky ready-timeout flag.

Function
REQ-011 SHALL synchronize each stage_ready bit through a 2-flop synchronizer; FSM uses only synchronized values (2-cycle latency).
REQ-012 SHALL implement FSM states IDLE, HOLD, WAIT_RDY, RUN, ERROR; stage index i, hold counter (HOLD_W bits) and timeout counter (TIMEOUT_W bits).
REQ-013 SHALL leave IDLE on the first rising edge after rst_in deasserts: enter HOLD, i=0, counters cleared.
REQ-014 SHALL in HOLD, increment the hold counter each cycle; when the counter is all-ones, clear rst_out[i] and enter WAIT_RDY. Counting that first edge as edge 1, rst_out[0] falls on edge 2^HOLD_W.
REQ-015 SHALL in WAIT_RDY, on synchronized stage_ready[i]=1, go to HOLD for i+1 with counters cleared. If i=STAGES-1, go to RUN and set done=1 on the same edge.
REQ-016 SHALL release stages strictly in index order; rst_out[j] for j>i stays 1 until stage j is reached.
REQ-017 SHALL in WAIT_RDY, on the timeout counter reaching all-ones without ready, enter ERROR: set timeout_err=1, set rst_out to all-ones, keep done=0.
REQ-018 SHALL remain in ERROR until sw_rst_req or rst_in.
REQ-019 SHALL in RUN, on any synchronized stage_ready bit dropping to 0, set rst_out to all-ones, clear done and restart at HOLD i=0; timeout_err is unchanged.
REQ-020 SHALL on sw_rst_req=1 in any state except IDLE, on the next edge: set rst_out to all-ones, clear done and timeout_err, and restart at HOLD i=0 with counters cleared. sw_rst_req takes priority over every other same-cycle event (ready, timeout, hold expiry).
REQ-021 SHALL ignore stage_ready bits of stages not yet reached.

Reset
REQ-022 SHALL, while rst_in=1, asynchronously force rst_out to all-ones, done=0, timeout_err=0, state=IDLE, i=0, counters=0, synchronizer flops=0.
REQ-023 SHALL apply the same initial values at configuration, with no rst_in pulse required.
REQ-024 SHALL, on rst_in asserting mid-sequence, abort immediately with no partial release of any stage.

Configuration
REQ-025 SHALL, when macro RESET_SEQ_TIMEOUT_EN is defined, include the timeout counter and the ERROR state per REQ-017/018.
REQ-026 SHALL, when RESET_SEQ_TIMEOUT_EN is undefined, wait in WAIT_RDY indefinitely, tie timeout_err to 0, and omit both the timeout counter and the ERROR state.

Structure
REQ-027 SHALL place the FSM state encodings (IDLE=0, HOLD=1, WAIT_RDY=2, RUN=3, ERROR=4, 3 bits) in a shared reset package/header, reusable by reset_stretch-family blocks.
REQ-028 SHALL instantiate one sub-module, sync_bit: a 2-flop synchronizer with asynchronous clear, used once per stage_ready bit.

Verification (STAGES=2, HOLD_W=2, TIMEOUT_W=4, macro defined)
REQ-029 SHALL cover: release rst_in with stage_ready=2'b11 held -> rst_out[0] falls on edge 4; rst_out[1] falls 4 edges after synchronized ready[0] is seen; done=1 together with synchronized ready[1]; timeout_err=0.
REQ-030 SHALL cover: stage_ready=2'b01 constant -> rst_out[0]=0; after 16 WAIT_RDY cycles for stage 1, timeout_err=1, rst_out=2'b11, done=0, held indefinitely.
REQ-031 SHALL cover: from the REQ-030 ERROR state, raise ready[1] then pulse sw_rst_req -> timeout_err=0 next edge, full sequence completes, done=1.
REQ-032 SHALL cover: in RUN, drop stage_ready[0] for 5 cycles -> within 3 edges rst_out=2'b11 and done=0; sequence restarts and completes once ready returns.
REQ-033 SHALL cover: assert rst_in during stage-1 HOLD -> rst_out=2'b11, done=0 asynchronously (before the next clk edge).
REQ-034 SHALL cover: sw_rst_req coincident with hold-counter expiry -> rst_out stays 2'b11, hold restarts from 0.
